// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one fixed-latency single-ported memory between the
// instruction-fetch port (I) and the load/store port (D). One transaction
// in flight at a time. D normally wins, but a streak counter lets I through
// after STARVE_MAX consecutive D wins while I was waiting.
//
// Transaction timeline, counted from the IDLE cycle that samples the request:
//   0          IDLE   winner chosen, address/data latched
//   1          ISSUE  MemEn high
//   2..MEM_LAT WAIT   (absent when MEM_LAT = 1)
//   1+MEM_LAT  CAPT   MemRData valid, captured into IRData/DRData
//   2+MEM_LAT  RESP   owner's Ack pulses, read data already visible
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          IReq,
  input  logic [AW-1:0] IAddr,
  output logic          IAck,
  output logic [DW-1:0] IRData,
  input  logic          DReq,
  input  logic          DWe,
  input  logic [AW-1:0] DAddr,
  input  logic [DW-1:0] DWData,
  output logic          DAck,
  output logic [DW-1:0] DRData,
  output logic          MemEn,
  output logic          MemWe,
  output logic [AW-1:0] MemAddr,
  output logic [DW-1:0] MemWData,
  input  logic [DW-1:0] MemRData,
  output logic          GntD,
  output logic          Busy
);

  localparam int CW = (MEM_LAT > 2) ? $clog2(MEM_LAT) : 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_CAPT  = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   wcnt_q;
  logic [SW-1:0]   streak_q, streak_d;
  logic            gnt_q, gnt_d;
  logic            we_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [DW-1:0]   ird_q, drd_q;
  logic            req_any;
  logic            starved;

  assign req_any = IReq | DReq;

  // Arbitration: D wins unless I has waited through a full streak of D grants.
  always_comb begin
    starved  = IReq && (streak_q == SW'(STARVE_MAX));
    gnt_d    = DReq && !starved;
    streak_d = '0;
    if (gnt_d && IReq)
      streak_d = (streak_q == SW'(STARVE_MAX)) ? streak_q : streak_q + SW'(1);
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (Rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; WAIT covers the memory latency beyond the first cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_any) state_d = S_ISSUE;
      S_ISSUE: state_d = (MEM_LAT > 1) ? S_WAIT : S_CAPT;
      S_WAIT:  if (wcnt_q == CW'(MEM_LAT - 2)) state_d = S_CAPT;
      S_CAPT:  state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode: strobes and acks are pure functions of the state.
  always_comb begin
    MemEn = (state_q == S_ISSUE);
    MemWe = (state_q == S_ISSUE) && we_q;
    IAck  = (state_q == S_RESP) && !gnt_q;
    DAck  = (state_q == S_RESP) && gnt_q;
    Busy  = (state_q != S_IDLE);
  end

  // Datapath: latch the winner's request, count WAIT cycles, capture read data.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      gnt_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      streak_q <= '0;
      wcnt_q   <= '0;
      ird_q    <= '0;
      drd_q    <= '0;
    end else begin
      if (state_q == S_IDLE && req_any) begin
        gnt_q    <= gnt_d;
        we_q     <= gnt_d && DWe;
        addr_q   <= gnt_d ? DAddr : IAddr;
        wdata_q  <= gnt_d ? DWData : '0;
        streak_q <= streak_d;
      end
      if (state_q == S_ISSUE)     wcnt_q <= '0;
      else if (state_q == S_WAIT) wcnt_q <= wcnt_q + CW'(1);
      // Stores complete without touching DRData.
      if (state_q == S_CAPT && !we_q) begin
        if (gnt_q) drd_q <= MemRData;
        else       ird_q <= MemRData;
      end
    end
  end

  assign MemAddr  = addr_q;
  assign MemWData = wdata_q;
  assign GntD     = gnt_q;
  assign IRData   = ird_q;
  assign DRData   = drd_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: main instance at MEM_LAT=2 checked every cycle
// against a transaction-phase model, second instance at MEM_LAT=1 for the
// single-cycle-memory fetch timing.
module tb_mem_port_arbiter;
  localparam int AW = 32, DW = 32, L0 = 2, L1 = 1, SMAX = 4;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;
  logic Rst;

  // main instance (MEM_LAT=2)
  logic          IReq, DReq, DWe;
  logic [AW-1:0] IAddr, DAddr;
  logic [DW-1:0] DWData;
  logic          IAck, DAck, MemEn, MemWe, GntD, Busy;
  logic [DW-1:0] IRData, DRData, MemWData, MemRData;
  logic [AW-1:0] MemAddr;

  // second instance (MEM_LAT=1)
  logic          IReq1;
  logic [AW-1:0] IAddr1;
  logic          IAck1, DAck1, MemEn1, MemWe1, GntD1, Busy1;
  logic [DW-1:0] IRData1, DRData1, MemWData1, MemRData1;
  logic [AW-1:0] MemAddr1;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(L0), .STARVE_MAX(SMAX)) u_dut (
    .Clk(Clk), .Rst(Rst), .IReq(IReq), .IAddr(IAddr), .IAck(IAck), .IRData(IRData),
    .DReq(DReq), .DWe(DWe), .DAddr(DAddr), .DWData(DWData), .DAck(DAck), .DRData(DRData),
    .MemEn(MemEn), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
    .MemRData(MemRData), .GntD(GntD), .Busy(Busy));

  mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(L1), .STARVE_MAX(SMAX)) u_dut1 (
    .Clk(Clk), .Rst(Rst), .IReq(IReq1), .IAddr(IAddr1), .IAck(IAck1), .IRData(IRData1),
    .DReq(1'b0), .DWe(1'b0), .DAddr('0), .DWData('0), .DAck(DAck1), .DRData(DRData1),
    .MemEn(MemEn1), .MemWe(MemWe1), .MemAddr(MemAddr1), .MemWData(MemWData1),
    .MemRData(MemRData1), .GntD(GntD1), .Busy(Busy1));

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] init0(input logic [7:0] a);
    return 32'h01010101 * {24'd0, a};
  endfunction
  function automatic logic [31:0] init1(input logic [7:0] a);
    return (a == 8'h10) ? 32'hDEADBEEF : ~{24'd0, a};
  endfunction

  // memories: initial contents from init*, written words tracked in an overlay
  logic [31:0] mem0 [256];
  bit          mw0  [256];
  logic [31:0] rd0a = '0, rd0b = '0, rd1a = '0;
  always @(posedge Clk) begin
    if (MemEn) begin
      if (MemWe) begin
        mem0[MemAddr[7:0]] <= MemWData;
        mw0[MemAddr[7:0]]  <= 1'b1;
      end
      rd0a <= mw0[MemAddr[7:0]] ? mem0[MemAddr[7:0]] : init0(MemAddr[7:0]);
    end
    rd0b <= rd0a;
    if (MemEn1) rd1a <= init1(MemAddr1[7:0]);
  end
  assign MemRData  = rd0b;
  assign MemRData1 = rd1a;

  // model of the main instance: p = cycles since the granting IDLE edge (0 = idle)
  int          p = 0, streak = 0;
  bit          started = 0, owner = 0, mwe = 0;
  logic [31:0] maddr = '0, mwd = '0, ird = '0, drd = '0, pend = '0;
  logic [31:0] memm [256];
  bit          mwm  [256];

  initial begin
    forever begin
      @(negedge Clk);
      if (started) begin
        chk("ctrl{en,we,iack,dack,gnt,busy}", {MemEn, MemWe, IAck, DAck, GntD, Busy},
            {p == 1, p == 1 && mwe, p == 2 + L0 && !owner, p == 2 + L0 && owner, owner, p != 0});
        chk("MemAddr", MemAddr, maddr);
        chk("MemWData", MemWData, mwd);
        chk("IRData", IRData, ird);
        chk("DRData", DRData, drd);
        chk("ack_excl", IAck & DAck, 0);
      end
      if (Rst) begin
        started = 1; p = 0; streak = 0; owner = 0; mwe = 0;
        maddr = '0; mwd = '0; ird = '0; drd = '0;
      end else if (started) begin
        if (p == 0) begin
          if (IReq || DReq) begin
            owner  = DReq && !(IReq && streak == SMAX);
            streak = (owner && IReq) ? ((streak < SMAX) ? streak + 1 : SMAX) : 0;
            maddr  = owner ? DAddr : IAddr;
            mwe    = owner && DWe;
            mwd    = owner ? DWData : '0;
            p      = 1;
          end
        end else if (p == 1) begin
          if (mwe) begin memm[maddr[7:0]] = mwd; mwm[maddr[7:0]] = 1; end
          else pend = mwm[maddr[7:0]] ? memm[maddr[7:0]] : init0(maddr[7:0]);
          p = 2;
        end else if (p == 1 + L0) begin
          if (!mwe) begin if (owner) drd = pend; else ird = pend; end
          p++;
        end else if (p == 2 + L0) p = 0;
        else p++;
      end
    end
  end

  task automatic step();
    @(posedge Clk); #1;
  endtask

  // Waits (bounded) for the given Ack; n = cycles from current cycle, -1 on timeout.
  task automatic wait_ack(input bit d, output int n, output bit we_seen);
    n = -1; we_seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge Clk);
      if (MemEn && MemWe) we_seen = 1;
      if (d ? DAck : IAck) begin n = k; break; end
      step();
    end
  endtask

  // Both ports requesting until nack acks seen; ord[i] = 1 if i-th ack was D.
  task automatic run_both(input int nack, output logic [9:0] ord, output int acks, output bit both);
    ord = '0; acks = 0; both = 0;
    IReq = 1; DReq = 1;
    for (int k = 0; k < 80; k++) begin
      @(negedge Clk);
      if (IAck && DAck) both = 1;
      if (IAck || DAck) begin ord[acks] = DAck; acks++; end
      step();
      if (acks == nack) break;
    end
    IReq = 0; DReq = 0;
  endtask

  int          n;
  bit          we, both, anyack;
  logic [9:0]  ord;
  int          acks;
  logic [3:0]  en_v, ack_v;
  logic [15:0] en16, ack16;
  logic [31:0] ird_v;
  logic        gnt_v;

  initial begin
    Rst = 1; IReq = 0; DReq = 0; DWe = 0; IAddr = '0; DAddr = '0; DWData = '0;
    IReq1 = 0; IAddr1 = '0;
    repeat (2) step();
    Rst = 0;
    @(negedge Clk);
    chk("rst_busy", Busy, 0);
    chk("rst_gntd", GntD, 0);
    chk("rst_memaddr", MemAddr, 0);
    chk("rst_drdata", DRData, 0);
    chk("rst_busy1", Busy1, 0);

    // single fetch, MEM_LAT=1
    step(); IReq1 = 1; IAddr1 = 32'h10;
    for (int k = 0; k < 4; k++) begin
      @(negedge Clk);
      en_v[k] = MemEn1; ack_v[k] = IAck1;
      if (k == 3) begin ird_v = IRData1; gnt_v = GntD1; end
      if (k < 3) step();
    end
    step(); IReq1 = 0;
    chk("t1_memen", en_v, 4'b0010);
    chk("t1_iack", ack_v, 4'b1000);
    chk("t1_irdata", ird_v, 32'hDEADBEEF);
    chk("t1_gntd", gnt_v, 0);

    // IReq held through IAck: back-to-back fetches every 4 cycles
    step(); IReq1 = 1; IAddr1 = 32'h20;
    for (int k = 0; k < 16; k++) begin
      @(negedge Clk);
      en16[k] = MemEn1; ack16[k] = IAck1;
      step();
    end
    IReq1 = 0;
    chk("t5_memen_spacing", en16, 16'h2222);
    chk("t5_iack_spacing", ack16, 16'h8888);

    // store then load, MEM_LAT=2
    step(); DReq = 1; DWe = 1; DAddr = 32'h40; DWData = 32'h55;
    wait_ack(1, n, we);
    chk("t2_st_lat", n, 4);
    chk("t2_st_we", we, 1);
    step(); DWe = 0; DWData = '0;
    wait_ack(1, n, we);
    chk("t2_ld_lat", n, 4);
    chk("t2_ld_we", we, 0);
    chk("t2_drdata", DRData, 32'h55);
    step(); DReq = 0;

    // both requesting continuously: starvation guard lets I in every 5th grant
    IAddr = 32'h20; DAddr = 32'h40; DWe = 0;
    run_both(10, ord, acks, both);
    chk("t3_order", ord, 10'b0111101111);
    chk("t3_acks", acks, 10);
    chk("t3_both_acks", both, 0);
    chk("t3_irdata", IRData, 32'h20202020);

    // reset in the WAIT cycle of a D load
    IReq = 1; DReq = 1; DAddr = 32'h40;
    step(); step();
    Rst = 1; IReq = 0; DReq = 0;
    @(negedge Clk);
    chk("t4_gnt_before", GntD, 1);
    step(); Rst = 0;
    @(negedge Clk);
    chk("t4_busy", Busy, 0);
    chk("t4_gntd", GntD, 0);
    chk("t4_memaddr", MemAddr, 0);
    chk("t4_drdata", DRData, 0);
    chk("t4_irdata", IRData, 0);
    anyack = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge Clk);
      if (IAck || DAck) anyack = 1;
      step();
    end
    chk("t4_no_ack", anyack, 0);
    // streak cleared: four D grants before I again
    run_both(5, ord, acks, both);
    chk("t4_streak_order", ord[4:0], 5'b01111);

    // DAddr changes mid-WAIT: latched address used, ack still issued
    DReq = 1; DWe = 0; DAddr = 32'h40;
    step(); step();
    DAddr = 32'h44;
    wait_ack(1, n, we);
    chk("t6_lat", n, 2);
    chk("t6_memaddr", MemAddr, 32'h40);
    chk("t6_drdata", DRData, 32'h55);
    step(); DReq = 0;

    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
